// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 bus master: request codes, FSM encoding, strobe bundle
// and the per-T-state strobe decode used by the master and its bench.
package z80_bus_pkg;

    localparam int DEFAULT_WAIT_LIMIT = 255;

    typedef enum logic [2:0] {
        REQ_MEM_RD = 3'b000,
        REQ_MEM_WR = 3'b001,
        REQ_IO_RD  = 3'b010,
        REQ_IO_WR  = 3'b011,
        REQ_M1     = 3'b100
    } req_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_TWA,
        ST_TW,
        ST_T3,
        ST_T4,
        ST_DONE
    } state_e;

    // The raw type code is kept as plain bits so reserved codes 101-111 stay representable.
    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } req_t;

    typedef struct packed {
        logic mreq_n;
        logic iorq_n;
        logic rd_n;
        logic wr_n;
        logic m1_n;
        logic rfsh_n;
        logic d_oe;
    } bus_ctl_t;

    localparam bus_ctl_t BUS_CTL_IDLE = '{
        mreq_n: 1'b1, iorq_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1,
        m1_n: 1'b1, rfsh_n: 1'b1, d_oe: 1'b0
    };

    function automatic logic is_reserved(input logic [2:0] kind);
        return kind > 3'b100;
    endfunction

    // Strobe levels for one T-state of a given cycle type.
    function automatic bus_ctl_t bus_ctl(input state_e st, input logic [2:0] kind);
        bus_ctl_t c;
        logic     addr_phase;
        logic     strobe_phase;
        c            = BUS_CTL_IDLE;
        addr_phase   = st inside {ST_T1, ST_T2, ST_TWA, ST_TW, ST_T3};
        strobe_phase = st inside {ST_T2, ST_TWA, ST_TW, ST_T3};
        case (kind)
            REQ_MEM_RD: begin
                if (addr_phase) begin
                    c.mreq_n = 1'b0;
                    c.rd_n   = 1'b0;
                end
            end
            REQ_MEM_WR: begin
                if (addr_phase) begin
                    c.mreq_n = 1'b0;
                    c.d_oe   = 1'b1;
                end
                if (strobe_phase) c.wr_n = 1'b0;
            end
            REQ_IO_RD: begin
                if (strobe_phase) begin
                    c.iorq_n = 1'b0;
                    c.rd_n   = 1'b0;
                end
            end
            REQ_IO_WR: begin
                if (addr_phase) c.d_oe = 1'b1;
                if (strobe_phase) begin
                    c.iorq_n = 1'b0;
                    c.wr_n   = 1'b0;
                end
            end
            REQ_M1: begin
                if (st inside {ST_T1, ST_T2, ST_TW}) begin
                    c.m1_n   = 1'b0;
                    c.mreq_n = 1'b0;
                    c.rd_n   = 1'b0;
                end else if (st inside {ST_T3, ST_T4}) begin
                    c.mreq_n = 1'b0;
                    c.rfsh_n = 1'b0;
                end
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/z80_bus_master_if.sv
// Request/response handshake plus Z80 external bus pins, seen from master and slave sides.
interface z80_bus_master_if;

    logic        req_valid;
    logic [2:0]  req_type;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_ready;

    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;

    logic        wait_n;
    logic [7:0]  d_in;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        m1_n;
    logic        rfsh_n;
    logic [15:0] a;
    logic [7:0]  d_out;
    logic        d_oe;

    modport master (
        input  req_valid, req_type, req_addr, req_wdata, wait_n, d_in,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, a, d_out, d_oe
    );

    modport slave (
        output req_valid, req_type, req_addr, req_wdata, wait_n, d_in,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, a, d_out, d_oe
    );

endinterface

// File: rtl/z80_refresh_ctr.sv
// Z80 refresh (R) register: low 7 bits count and wrap, bit 7 is held.
module z80_refresh_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    output logic [7:0] r
);

    logic [7:0] r_q;
    logic [7:0] r_d;

    always_comb begin
        r_d = r_q;
        if (inc) r_d = {r_q[7], r_q[6:0] + 7'd1};
    end

    always_ff @(posedge clk) begin
        if (rst) r_q <= '0;
        else     r_q <= r_d;
    end

    assign r = r_q;

endmodule

// File: rtl/z80_bus_master.sv
// Z80-style bus master: turns one latched request into a T-state accurate
// memory, I/O or opcode-fetch cycle with registered strobes.
module z80_bus_master
    import z80_bus_pkg::*;
#(
    parameter int WAIT_LIMIT = DEFAULT_WAIT_LIMIT
) (
    input logic               clk,
    input logic               rst,
    z80_bus_master_if.master  bus
);

    localparam int              CNT_W     = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    req_t             req_q, req_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             abort_q, abort_d;
    logic [7:0]       fetch_q, fetch_d;
    bus_ctl_t         ctl_q, ctl_d;
    logic [15:0]      a_q, a_d;
    logic [7:0]       d_out_q, d_out_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [7:0]       rsp_rdata_q, rsp_rdata_d;
    logic             ready_q, ready_d;
    logic [7:0]       r;
    logic             accept;
    logic             refresh_inc;
    logic             is_io;

    assign accept      = bus.req_valid && ready_q;
    assign refresh_inc = (state_q == ST_T4);
    assign is_io       = (req_q.kind == REQ_IO_RD) || (req_q.kind == REQ_IO_WR);

    z80_refresh_ctr u_refresh (
        .clk (clk),
        .rst (rst),
        .inc (refresh_inc),
        .r   (r)
    );

    // NOTE: every output of always_comb gets a default first so no path leaves a latch.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        wait_cnt_d = wait_cnt_q;
        abort_d    = abort_q;
        fetch_d    = fetch_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_d   = '{kind: bus.req_type, addr: bus.req_addr, wdata: bus.req_wdata};
                    abort_d = 1'b0;
                    state_d = is_reserved(bus.req_type) ? ST_DONE : ST_T1;
                end
            end
            ST_T1: state_d = ST_T2;
            ST_T2: begin
                if (is_io) begin
                    state_d = ST_TWA;
                end else if (!bus.wait_n) begin
                    state_d    = ST_TW;
                    wait_cnt_d = CNT_ONE;
                end else begin
                    state_d = ST_T3;
                end
            end
            ST_TWA: begin
                if (!bus.wait_n) begin
                    state_d    = ST_TW;
                    wait_cnt_d = CNT_ONE;
                end else begin
                    state_d = ST_T3;
                end
            end
            ST_TW: begin
                if (bus.wait_n) begin
                    state_d = ST_T3;
                end else if (wait_cnt_q == CNT_LIMIT) begin
                    state_d = ST_T3;
                    abort_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_ONE;
                end
            end
            ST_T3:   state_d = (req_q.kind == REQ_M1) ? ST_T4 : ST_DONE;
            ST_T4:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Opcode byte is taken as the last read T-state ends, before refresh takes the bus.
        if ((req_q.kind == REQ_M1) && (state_q inside {ST_T2, ST_TW}) && (state_d == ST_T3))
            fetch_d = bus.d_in;

        ctl_d = bus_ctl(state_d, req_d.kind);

        a_d = a_q;
        if (!(state_d inside {ST_IDLE, ST_DONE}))
            a_d = ctl_d.rfsh_n ? req_d.addr : {8'h00, r};

        d_out_d = ctl_d.d_oe ? req_d.wdata : d_out_q;

        rsp_valid_d = (state_d == ST_DONE);
        rsp_err_d   = (state_d == ST_DONE) && (is_reserved(req_d.kind) || abort_d);
        rsp_rdata_d = rsp_rdata_q;
        if (state_d == ST_DONE) begin
            case (req_d.kind)
                REQ_MEM_RD, REQ_IO_RD: rsp_rdata_d = bus.d_in;
                REQ_MEM_WR, REQ_IO_WR: rsp_rdata_d = 8'h00;
                REQ_M1:                rsp_rdata_d = fetch_d;
                default:               rsp_rdata_d = 8'hFF;
            endcase
        end

        ready_d = (state_d == ST_IDLE);
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            wait_cnt_q  <= '0;
            abort_q     <= 1'b0;
            fetch_q     <= 8'h00;
            ctl_q       <= BUS_CTL_IDLE;
            a_q         <= 16'h0000;
            d_out_q     <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 8'h00;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            wait_cnt_q  <= wait_cnt_d;
            abort_q     <= abort_d;
            fetch_q     <= fetch_d;
            ctl_q       <= ctl_d;
            a_q         <= a_d;
            d_out_q     <= d_out_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mreq_n    = ctl_q.mreq_n;
    assign bus.iorq_n    = ctl_q.iorq_n;
    assign bus.rd_n      = ctl_q.rd_n;
    assign bus.wr_n      = ctl_q.wr_n;
    assign bus.m1_n      = ctl_q.m1_n;
    assign bus.rfsh_n    = ctl_q.rfsh_n;
    assign bus.d_oe      = ctl_q.d_oe;
    assign bus.a         = a_q;
    assign bus.d_out     = d_out_q;

endmodule

// File: tb/tb_z80_bus_master.sv
// Directed bench for z80_bus_master: walks each cycle type, wait/abort, refresh wrap and reset.
module tb_z80_bus_master;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   both_hi = 0;

    z80_bus_master_if bus_if ();

    z80_bus_master #(.WAIT_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] strobes;
    assign strobes = {bus_if.mreq_n, bus_if.iorq_n, bus_if.rd_n,
                      bus_if.wr_n, bus_if.m1_n, bus_if.rfsh_n};

    always @(negedge clk) if (bus_if.rsp_valid === 1'b1 && bus_if.req_ready === 1'b1) both_hi++;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int          lat, n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh, n_oe, n_oe_bad, n_addr_bad, n_m1_in_rfsh;
    logic [15:0] rfsh_a;
    logic [7:0]  got_rdata;
    logic        got_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and profile the strobes cycle by cycle until the response.
    task automatic txn(input logic [2:0] kind, input logic [15:0] addr, input logic [7:0] wdata,
                       input logic [7:0] din, input int wait_from, input int wait_len, input bit hold);
        bit done;
        int cyc;
        check("ready_before", bus_if.req_ready, 1);
        bus_if.req_valid = 1'b1;
        bus_if.req_type  = kind;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wdata;
        bus_if.d_in      = din;
        bus_if.wait_n    = 1'b1;
        tick();
        if (hold) begin
            bus_if.req_type  = 3'b001;
            bus_if.req_addr  = 16'hFFFF;
            bus_if.req_wdata = 8'h00;
        end else begin
            bus_if.req_valid = 1'b0;
        end
        {n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh} = '0;
        {n_oe, n_oe_bad, n_addr_bad, n_m1_in_rfsh} = '0;
        lat    = 0;
        rfsh_a = 16'hDEAD;
        done   = 1'b0;
        cyc    = 1;
        while (!done && cyc <= 40) begin
            bus_if.wait_n = !(cyc >= wait_from && cyc < wait_from + wait_len);
            if (bus_if.rsp_valid === 1'b1) begin
                done             = 1'b1;
                lat              = cyc;
                got_rdata        = bus_if.rsp_rdata;
                got_err          = bus_if.rsp_err;
                bus_if.req_valid = 1'b0;
                bus_if.wait_n    = 1'b1;
            end else begin
                if (!bus_if.mreq_n) n_mreq++;
                if (!bus_if.iorq_n) n_iorq++;
                if (!bus_if.rd_n)   n_rd++;
                if (!bus_if.wr_n)   n_wr++;
                if (!bus_if.m1_n)   n_m1++;
                if (!bus_if.rfsh_n) begin
                    n_rfsh++;
                    rfsh_a = bus_if.a;
                    if (!bus_if.m1_n) n_m1_in_rfsh++;
                end else if ((!bus_if.mreq_n || !bus_if.iorq_n) && bus_if.a !== addr) begin
                    n_addr_bad++;
                end
                if (bus_if.d_oe) begin
                    n_oe++;
                    if (bus_if.d_out !== wdata) n_oe_bad++;
                end
            end
            tick();
            cyc++;
        end
        check("rsp_seen", done, 1);
        check("rsp_one_cycle", bus_if.rsp_valid, 0);
        check("ready_after", bus_if.req_ready, 1);
    endtask

    initial begin
        rst              = 1'b1;
        bus_if.req_valid = 1'b0;
        bus_if.req_type  = 3'b000;
        bus_if.req_addr  = 16'h0000;
        bus_if.req_wdata = 8'h00;
        bus_if.wait_n    = 1'b1;
        bus_if.d_in      = 8'h00;

        // Reset state
        tick();
        tick();
        check("rst_strobes", strobes, 6'h3F);
        check("rst_doe", bus_if.d_oe, 0);
        check("rst_a", bus_if.a, 16'h0000);
        check("rst_dout", bus_if.d_out, 8'h00);
        check("rst_rsp_valid", bus_if.rsp_valid, 0);
        check("rst_rsp_err", bus_if.rsp_err, 0);
        check("rst_rsp_rdata", bus_if.rsp_rdata, 8'h00);
        check("rst_ready", bus_if.req_ready, 0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", bus_if.req_ready, 1);

        // Memory read, no waits
        txn(3'b000, 16'h8000, 8'h00, 8'h5A, 0, 0, 1'b0);
        check("mrd_mreq", n_mreq, 3);
        check("mrd_rd", n_rd, 3);
        check("mrd_others", n_iorq + n_wr + n_m1 + n_rfsh + n_oe, 0);
        check("mrd_addr", n_addr_bad, 0);
        check("mrd_lat", lat, 4);
        check("mrd_rdata", got_rdata, 8'h5A);
        check("mrd_err", got_err, 0);

        // Memory write with two wait states
        txn(3'b001, 16'hC000, 8'hA5, 8'h00, 2, 2, 1'b0);
        check("mwr_wr", n_wr, 4);
        check("mwr_mreq", n_mreq, 5);
        check("mwr_oe", n_oe, 5);
        check("mwr_dout", n_oe_bad, 0);
        check("mwr_rd", n_rd, 0);
        check("mwr_addr", n_addr_bad, 0);
        check("mwr_lat", lat, 6);
        check("mwr_rdata", got_rdata, 8'h00);
        check("mwr_err", got_err, 0);

        // I/O read, automatic TWA only
        txn(3'b010, 16'h00C0, 8'h00, 8'h33, 0, 0, 1'b0);
        check("iord_iorq", n_iorq, 3);
        check("iord_rd", n_rd, 3);
        check("iord_mreq", n_mreq, 0);
        check("iord_addr", n_addr_bad, 0);
        check("iord_lat", lat, 5);
        check("iord_rdata", got_rdata, 8'h33);

        // I/O write with one extra wait after TWA
        txn(3'b011, 16'h0042, 8'h7E, 8'h00, 3, 1, 1'b0);
        check("iowr_iorq", n_iorq, 4);
        check("iowr_wr", n_wr, 4);
        check("iowr_oe", n_oe, 5);
        check("iowr_dout", n_oe_bad, 0);
        check("iowr_mreq", n_mreq, 0);
        check("iowr_lat", lat, 6);
        check("iowr_rdata", got_rdata, 8'h00);

        // 129 opcode fetches: refresh address walks 00..7F then wraps to 00
        for (int i = 0; i < 129; i++) begin
            logic [7:0] din;
            din = 8'(i) ^ 8'hC3;
            txn(3'b100, 16'h1234 + 16'(i), 8'h00, din, 0, 0, 1'b0);
            if (i == 0) begin
                check("m1_m1", n_m1, 2);
                check("m1_rd", n_rd, 2);
                check("m1_mreq", n_mreq, 4);
                check("m1_lat", lat, 5);
            end
            check("m1_rfsh_a", rfsh_a, {8'h00, 1'b0, 7'(i)});
            check("m1_rfsh_len", n_rfsh, 2);
            check("m1_high_in_rfsh", n_m1_in_rfsh, 0);
            check("m1_rdata", got_rdata, din);
        end

        // Wait stuck low: aborted after four TW states
        txn(3'b000, 16'h3000, 8'h00, 8'h11, 2, 100, 1'b0);
        check("abort_mreq", n_mreq, 7);
        check("abort_lat", lat, 8);
        check("abort_err", got_err, 1);
        check("abort_rdata", got_rdata, 8'h11);

        // Reserved type
        txn(3'b110, 16'h1234, 8'h00, 8'h00, 0, 0, 1'b0);
        check("rsv_strobes", n_mreq + n_iorq + n_rd + n_wr + n_m1 + n_rfsh + n_oe, 0);
        check("rsv_lat", lat, 1);
        check("rsv_rdata", got_rdata, 8'hFF);
        check("rsv_err", got_err, 1);

        // Error flag does not stick to the next transaction
        txn(3'b000, 16'h2000, 8'h00, 8'h99, 0, 0, 1'b0);
        check("clean_err", got_err, 0);
        check("clean_rdata", got_rdata, 8'h99);

        // New request held valid while busy must be ignored
        txn(3'b000, 16'h8001, 8'h00, 8'h6C, 0, 0, 1'b1);
        check("hold_wr", n_wr, 0);
        check("hold_mreq", n_mreq, 3);
        check("hold_addr", n_addr_bad, 0);
        check("hold_rdata", got_rdata, 8'h6C);
        tick();
        check("hold_no_restart", bus_if.mreq_n, 1);

        // Reset while in a wait state
        bus_if.req_valid = 1'b1;
        bus_if.req_type  = 3'b000;
        bus_if.req_addr  = 16'h4000;
        bus_if.d_in      = 8'h00;
        tick();
        bus_if.req_valid = 1'b0;
        tick();
        bus_if.wait_n = 1'b0;
        tick();
        check("tw_mreq", bus_if.mreq_n, 0);
        rst = 1'b1;
        tick();
        check("midrst_strobes", strobes, 6'h3F);
        check("midrst_rsp_valid", bus_if.rsp_valid, 0);
        check("midrst_ready", bus_if.req_ready, 0);
        check("midrst_a", bus_if.a, 16'h0000);
        rst           = 1'b0;
        bus_if.wait_n = 1'b1;
        tick();
        check("midrst_ready_after", bus_if.req_ready, 1);
        begin
            int rv;
            rv = 0;
            for (int i = 0; i < 6; i++) begin
                if (bus_if.rsp_valid !== 1'b0) rv++;
                tick();
            end
            check("midrst_no_rsp", rv, 0);
        end

        // Refresh register cleared by reset
        txn(3'b100, 16'h0100, 8'h00, 8'h00, 0, 0, 1'b0);
        check("r_after_rst", rfsh_a, 16'h0000);

        check("rsp_and_ready", both_hi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/z80_bus_master.md
Z80_BUS_MASTER -- requirements
Module: z80_bus_master

Interface
REQ-001 Parameter WAIT_LIMIT, default 255, max consecutive TW states before abort.
REQ-002 CLK  in  1  single clock; one CLK period = one T-state; all state and outputs change on rising edge only.
REQ-003 RST  in  1  synchronous, active-high reset.
REQ-004 REQ_VALID  in  1  transaction request.
REQ-005 REQ_TYPE  in  3  000 mem rd, 001 mem wr, 010 io rd, 011 io wr, 100 opcode fetch (M1), 101-111 reserved.
REQ-006 REQ_ADDR  in  16  bus address; REQ_WDATA  in  8  write data.
REQ-007 REQ_READY  out  1  request accepted when REQ_VALID and REQ_READY are high on the same edge.
REQ-008 RSP_VALID  out  1  one-cycle completion pulse; RSP_RDATA  out  8  read data; RSP_ERR  out  1  abort/reserved flag.
REQ-009 WAIT_N  in  1  active-low bus wait; D_IN  in  8  bus data in.
REQ-010 MREQ, IORQ, RD, WR, M1, RFSH  out  1 each  active-low bus strobes, registered.
REQ-011 A  out  16  bus address; D_OUT  out  8  bus data out; D_OE  out  1  data driver enable, active-high.

Function
REQ-012 FSM states: IDLE, T1, T2, TWA, TW, T3, T4, DONE; REQ_READY SHALL be 1 only in IDLE.
REQ-013 On accept, the request is latched and T1 is entered on the next edge; in IDLE all strobes are 1, D_OE 0, A holds last value.
REQ-014 Mem rd: T1-T2-[TW*]-T3-DONE; A=addr, MREQ=0, RD=0 throughout T1..T3; D_IN captured at end of T3.
REQ-015 Mem wr: T1-T2-[TW*]-T3-DONE; MREQ=0 and D_OE=1 in T1..T3; WR=0 in T2..T3 only; D_OUT=REQ_WDATA.
REQ-016 IO rd/wr: T1-T2-TWA-[TW*]-T3-DONE; IORQ and RD/WR=0 in T2..T3, 1 in T1; TWA is always inserted; D_OE as mem wr for io wr.
REQ-017 WAIT_N sampled at end of T2 (mem/M1) or TWA (io): 0 enters TW; in TW, remain while WAIT_N=0, exit to T3 (or T3 refresh for M1) when 1.
REQ-018 M1: T1-T2-[TW*]-T3-T4-DONE; M1=0, MREQ=0, RD=0 in T1..T2/TW; D_IN captured at end of last T2/TW.
REQ-019 M1 refresh: in T3,T4 A={8'h00, R[7:0]}, MREQ=0, RFSH=0, RD=1, M1=1.
REQ-020 R register: 8 bits, reset 0; R[6:0] increments by 1 on T4 exit, 7F wraps to 00, R[7] never changes.
REQ-021 Wait abort: the TW count reaching WAIT_LIMIT forces exit as if WAIT_N=1 and sets RSP_ERR for that transaction.
REQ-022 DONE: all strobes 1, D_OE 0, RSP_VALID=1 for exactly one cycle with RSP_RDATA (0x00 for writes), then IDLE.
REQ-023 Reserved REQ_TYPE: no strobe activity; T1 skipped; DONE next cycle with RSP_ERR=1, RSP_RDATA=0xFF.
REQ-024 REQ_VALID while busy is ignored (not latched); RSP_VALID and REQ_READY never high in same cycle.

Reset
REQ-025 RST high on any edge SHALL force IDLE, strobes 1, D_OE 0, A=0, D_OUT=0, R=0, RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0, REQ_READY=0 that cycle, 1 the cycle after RST falls.
REQ-026 Reset mid-transaction SHALL abort without RSP_VALID for that transaction.

Structure
REQ-027 Shared package z80_bus_pkg holds REQ_TYPE codes, FSM state encoding, default WAIT_LIMIT.
REQ-028 Refresh register in sub-module z80_refresh_ctr (inc enable, 7-bit wrap, bit 7 hold).

Verification
REQ-029 Mem rd 0x8000, WAIT_N=1, D_IN=0x5A -> MREQ/RD low exactly 3 cycles, RSP_VALID next cycle, RSP_RDATA=0x5A.
REQ-030 Mem wr 0xC000/0xA5 with WAIT_N=0 for 2 cycles at T2 -> 2 TW, WR low 1+2+1 cycles, D_OE=1 with D_OUT=0xA5, RSP_ERR=0.
REQ-031 IO rd A=0x00C0, D_IN=0x33 -> IORQ/RD low 3 cycles (T2,TWA,T3), RSP_RDATA=0x33.
REQ-032 129 M1 fetches from reset -> refresh A low byte 0x00..0x7F then 0x00, RFSH low 2 cycles each, M1 high during RFSH.
REQ-033 WAIT_N stuck 0, WAIT_LIMIT=4 -> exactly 4 TW, RSP_ERR=1; REQ_TYPE=110 -> no strobes, RSP_RDATA=0xFF, RSP_ERR=1.
REQ-034 RST asserted in TW of mem rd -> next cycle all strobes 1, no RSP_VALID, REQ_READY=1 after release.
